frog_key_conditioner: RTL and testbench

Converts the raw 16-bit USB keycode from the Nios keycode PIO into clean, frame-aligned hop requests (`up`/`down`/`left`/`right`) for the frog motion block. It sits between the keycode export and the frog, replacing the direct keycode compares. It guarantees that each key press produces exactly one hop, held for exactly one frame period. Optionally, it adds auto-repeat while a key is held, and it also supplies a sticky last-direction indicator for LEDG.

---
 rtl/frog_key_conditioner.sv | 139 +++++++++++++
 tb/tb_frog_key_conditioner.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/frog_key_conditioner.sv
// Keycode-to-hop conditioner: turns arrow keycodes into one-frame hop requests aligned to vsync.
// Define KEYCOND_AUTOREPEAT_EN to compile in hold-to-repeat (REPEAT_DELAY / REPEAT_PERIOD).
module frog_key_conditioner #(
   parameter int REPEAT_DELAY  = 20,
   parameter int REPEAT_PERIOD = 8
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic [15:0] keycode,
   input  logic        frame_clk,
   output logic        up,
   output logic        down,
   output logic        left,
   output logic        right,
   output logic        hop_any,
   output logic [3:0]  last_dir
);

   if (REPEAT_DELAY < 1 || REPEAT_DELAY > 63 || REPEAT_PERIOD < 1 || REPEAT_PERIOD > 63) begin : g_bad_cfg
      $error("frog_key_conditioner: REPEAT_DELAY/REPEAT_PERIOD must be 1..63");
   end

   logic [15:0] r_kc;
   logic        r_kc_vld, r_dec_vld;
   logic [3:0]  r_dec_prev, r_pending, r_hop, r_last;
   logic        r_hop_any;
   logic        r_fs1, r_fs2, r_fs3, r_tick;
   logic [3:0]  w_dec, w_pend, w_next, w_rep_req;
   logic        w_press;

   // one-hot direction: [0] right, [1] down, [2] up, [3] left
   always_comb begin
      w_dec = 4'b0000;
      case (r_kc)
         16'h004F: w_dec = 4'b0001;
         16'h0051: w_dec = 4'b0010;
         16'h0052: w_dec = 4'b0100;
         16'h0050: w_dec = 4'b1000;
         default:  w_dec = 4'b0000;
      endcase
   end

   // r_dec_vld masks the first decode after reset so a held key is not a press
   assign w_press = r_dec_vld && (w_dec != r_dec_prev) && (w_dec != 4'b0000);
   assign w_pend  = w_press ? w_dec : r_pending;
   assign w_next  = w_pend | w_rep_req;

`ifdef KEYCOND_AUTOREPEAT_EN
   typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} state_t;
   localparam logic [5:0] DLY = 6'(REPEAT_DELAY);
   localparam logic [5:0] PER = 6'(REPEAT_PERIOD);

   state_t     r_state;
   logic [5:0] r_cnt;
   logic [5:0] w_cnt_inc;

   assign w_cnt_inc = (r_cnt == 6'd63) ? r_cnt : r_cnt + 6'd1;

   always_comb begin
      w_rep_req = 4'b0000;
      if (r_tick && !w_press && (w_dec != 4'b0000) &&
          (((r_state == S_DELAY) && (w_cnt_inc == DLY)) ||
           ((r_state == S_REPEAT) && (w_cnt_inc == PER))))
         w_rep_req = w_dec;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state <= S_IDLE;
         r_cnt   <= 6'd0;
      end else if (w_dec == 4'b0000) begin
         r_state <= S_IDLE;
         r_cnt   <= 6'd0;
      end else if (w_press) begin
         r_state <= S_DELAY;
         r_cnt   <= 6'd0;
      end else if (r_tick) begin
         case (r_state)
            S_DELAY: begin
               if (w_cnt_inc == DLY) begin
                  r_state <= S_REPEAT;
                  r_cnt   <= 6'd0;
               end else begin
                  r_cnt   <= w_cnt_inc;
               end
            end
            S_REPEAT: r_cnt <= (w_cnt_inc == PER) ? 6'd0 : w_cnt_inc;
            default:  r_cnt <= 6'd0;
         endcase
      end
   end
`else
   assign w_rep_req = 4'b0000;
`endif

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_kc       <= 16'h0000;
         r_kc_vld   <= 1'b0;
         r_dec_vld  <= 1'b0;
         r_dec_prev <= 4'b0000;
         r_pending  <= 4'b0000;
         r_hop      <= 4'b0000;
         r_hop_any  <= 1'b0;
         r_last     <= 4'b0000;
         r_fs1      <= 1'b0;
         r_fs2      <= 1'b0;
         r_fs3      <= 1'b0;
         r_tick     <= 1'b0;
      end else begin
         r_kc       <= keycode;
         r_kc_vld   <= 1'b1;
         r_dec_vld  <= r_kc_vld;
         r_dec_prev <= w_dec;
         r_fs1      <= frame_clk;
         r_fs2      <= r_fs1;
         r_fs3      <= r_fs2;
         r_tick     <= r_fs2 & ~r_fs3;
         if (w_press)
            r_last <= w_dec;
         // a press coinciding with the tick rides along in w_pend
         if (r_tick) begin
            r_hop     <= w_next;
            r_hop_any <= |w_next;
            r_pending <= 4'b0000;
         end else begin
            r_pending <= w_pend;
         end
      end
   end

   assign right    = r_hop[0];
   assign down     = r_hop[1];
   assign up       = r_hop[2];
   assign left     = r_hop[3];
   assign hop_any  = r_hop_any;
   assign last_dir = r_last;

endmodule

// File: tb/tb_frog_key_conditioner.sv
// Directed bench for frog_key_conditioner: vector table plus coincident-tick, long-hold and reset sequences.
module tb_frog_key_conditioner;

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic [15:0] keycode;
   logic        frame_clk;
   logic        up, down, left, right, hop_any;
   logic [3:0]  last_dir;
   logic [3:0]  hops;

   int n_cmp = 0;
   int n_bad = 0;

   always #10 Clk = ~Clk;

   frog_key_conditioner dut (
      .Clk(Clk), .Reset_n(Reset_n), .keycode(keycode), .frame_clk(frame_clk),
      .up(up), .down(down), .left(left), .right(right),
      .hop_any(hop_any), .last_dir(last_dir)
   );

   assign hops = {left, up, down, right};

   typedef struct {
      logic [15:0] kc1;
      logic [15:0] kc2;
      logic [3:0]  exp_hop;
      logic [3:0]  exp_last;
   } vec_t;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // 20-clock frame: vsync high 10, low 10; hop sampled mid-frame and at frame end
   task automatic do_frame(output logic [3:0] h_mid, output logic a_mid, output logic [3:0] h_end);
      @(negedge Clk) frame_clk = 1'b1;
      repeat (6) @(negedge Clk);
      h_mid = hops;
      a_mid = hop_any;
      repeat (4) @(negedge Clk);
      frame_clk = 1'b0;
      repeat (10) @(negedge Clk);
      h_end = hops;
   endtask

   function automatic logic exp_rep(input int f);
`ifdef KEYCOND_AUTOREPEAT_EN
      return (f == 1) || (f == 20) || (f == 28) || (f == 36);
`else
      return (f == 1);
`endif
   endfunction

   initial begin
      vec_t vecs[9];
      logic [3:0] hm, he;
      logic       am;
      int         pulses;

      vecs[0] = '{16'h0052, 16'h0052, 4'b0100, 4'b0100};
      vecs[1] = '{16'h0051, 16'h004F, 4'b0001, 4'b0001};
      vecs[2] = '{16'h0050, 16'h0050, 4'b1000, 4'b1000};
      vecs[3] = '{16'h0051, 16'h0051, 4'b0010, 4'b0010};
      vecs[4] = '{16'h1A50, 16'h1A50, 4'b0000, 4'b0010};
      vecs[5] = '{16'h0000, 16'h0000, 4'b0000, 4'b0010};
      vecs[6] = '{16'h004F, 16'h0050, 4'b1000, 4'b1000};
      vecs[7] = '{16'h0150, 16'h0000, 4'b0000, 4'b1000};
      vecs[8] = '{16'h0052, 16'h1A50, 4'b0100, 4'b0100};

      Reset_n   = 1'b0;
      keycode   = 16'h0000;
      frame_clk = 1'b0;
      repeat (3) @(negedge Clk);
      chk("reset_hops", {12'h0, hops}, 16'h0);
      chk("reset_hop_any", {15'h0, hop_any}, 16'h0);
      chk("reset_last_dir", {12'h0, last_dir}, 16'h0);
      Reset_n = 1'b1;
      repeat (4) @(negedge Clk);

      for (int i = 0; i < 9; i++) begin
         keycode = vecs[i].kc1;
         repeat (3) @(negedge Clk);
         keycode = vecs[i].kc2;
         repeat (3) @(negedge Clk);
         do_frame(hm, am, he);
         chk($sformatf("vec%0d_hop_mid", i), {12'h0, hm}, {12'h0, vecs[i].exp_hop});
         chk($sformatf("vec%0d_hop_any", i), {15'h0, am}, {15'h0, |vecs[i].exp_hop});
         chk($sformatf("vec%0d_hop_end", i), {12'h0, he}, {12'h0, vecs[i].exp_hop});
         chk($sformatf("vec%0d_last_dir", i), {12'h0, last_dir}, {12'h0, vecs[i].exp_last});
         keycode = 16'h0000;
         repeat (3) @(negedge Clk);
         do_frame(hm, am, he);
         chk($sformatf("vec%0d_no_dup", i), {12'h0, hm}, 16'h0);
      end

      // press registered in the same cycle as the frame tick
      @(negedge Clk) frame_clk = 1'b1;
      @(negedge Clk);
      @(negedge Clk);
      keycode = 16'h004F;
      @(negedge Clk);
      chk("coinc_before", {12'h0, hops}, 16'h0);
      @(negedge Clk);
      chk("coinc_hop", {12'h0, hops}, 16'h0001);
      chk("coinc_hop_any", {15'h0, hop_any}, 16'h1);
      chk("coinc_last_dir", {12'h0, last_dir}, 16'h0001);
      repeat (6) @(negedge Clk);
      frame_clk = 1'b0;
      repeat (10) @(negedge Clk);
      do_frame(hm, am, he);
      chk("coinc_no_dup", {12'h0, hm}, 16'h0);
      keycode = 16'h0000;
      repeat (3) @(negedge Clk);

      // 40-frame hold of left
      keycode = 16'h0050;
      repeat (3) @(negedge Clk);
      pulses = 0;
      for (int f = 1; f <= 40; f++) begin
         do_frame(hm, am, he);
         if (hm == 4'b1000) pulses++;
         chk($sformatf("hold_f%0d_mid", f), {12'h0, hm}, exp_rep(f) ? 16'h0008 : 16'h0000);
         chk($sformatf("hold_f%0d_end", f), {12'h0, he}, exp_rep(f) ? 16'h0008 : 16'h0000);
      end
`ifdef KEYCOND_AUTOREPEAT_EN
      chk("hold_pulses", 16'(pulses), 16'd4);
`else
      chk("hold_pulses", 16'(pulses), 16'd1);
`endif
      keycode = 16'h0000;
      repeat (3) @(negedge Clk);

      // reset mid-hop with up still held
      keycode = 16'h0052;
      repeat (3) @(negedge Clk);
      @(negedge Clk) frame_clk = 1'b1;
      repeat (6) @(negedge Clk);
      chk("rst_pre_up", {12'h0, hops}, 16'h0004);
      #2 Reset_n = 1'b0;
      #1;
      chk("rst_async_hops", {12'h0, hops}, 16'h0);
      chk("rst_async_hop_any", {15'h0, hop_any}, 16'h0);
      chk("rst_async_last", {12'h0, last_dir}, 16'h0);
      frame_clk = 1'b0;
      repeat (3) @(negedge Clk);
      Reset_n = 1'b1;
      repeat (3) @(negedge Clk);
      for (int f = 0; f < 2; f++) begin
         do_frame(hm, am, he);
         chk($sformatf("rst_held_f%0d", f), {12'h0, hm}, 16'h0);
      end
      chk("rst_held_last", {12'h0, last_dir}, 16'h0);
      keycode = 16'h0000;
      repeat (3) @(negedge Clk);
      keycode = 16'h0052;
      repeat (3) @(negedge Clk);
      do_frame(hm, am, he);
      chk("rst_repress_up", {12'h0, hm}, 16'h0004);
      chk("rst_repress_last", {12'h0, last_dir}, 16'h0004);
      keycode = 16'h0000;
      repeat (3) @(negedge Clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
